// File: rtl/gcd_engine.sv
// Iterative subtractive-Euclid GCD unit with valid/ready handshakes on both sides.
// Define GCD_ITER_COUNT_EN to add the iter_cnt output (saturating subtraction count).
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready=1)
// CALC  | subtracting smaller from larger until a zero or equal operand appears
// DONE  | presenting gcd_out/zero_err until out_ready
module gcd_engine #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] gcd_out,
`ifdef GCD_ITER_COUNT_EN
   output logic             zero_err,
   output logic [WIDTH-1:0] iter_cnt
`else
   output logic             zero_err
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             accept;
   logic             finish;
   logic             both_zero;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      both_zero  = (x == '0) && (y == '0);
      finish     = (x == '0) || (y == '0) || (x == y);
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept     = 1'b1;
               next_state = CALC;
            end
         end
         CALC: begin
            if (finish) begin
               next_state = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Result registers are only written on the CALC exit edge, so they hold through DONE and IDLE.
   always_ff @(posedge clock) begin
      if (reset) begin
         x        <= '0;
         y        <= '0;
         gcd_out  <= '0;
         zero_err <= 1'b0;
      end else if (accept) begin
         x <= a_in;
         y <= b_in;
      end else if (state == CALC) begin
         if (both_zero) begin
            gcd_out  <= '0;
            zero_err <= 1'b1;
         end else if (x == '0) begin
            gcd_out  <= y;
            zero_err <= 1'b0;
         end else if (finish) begin
            gcd_out  <= x;
            zero_err <= 1'b0;
         end else if (x > y) begin
            x <= x - y;
         end else begin
            y <= y - x;
         end
      end
   end

`ifdef GCD_ITER_COUNT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         iter_cnt <= '0;
      end else if (accept) begin
         iter_cnt <= '0;
      end else if ((state == CALC) && !finish && (iter_cnt != '1)) begin
         iter_cnt <= iter_cnt + WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine (WIDTH=8): reset, results, latency, zero cases,
// output back-pressure, mid-job reset and streaming.
module tb_gcd_engine;

   localparam int WIDTH = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a_in = '0;
   logic [WIDTH-1:0] b_in = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] gcd_out;
   logic             zero_err;
`ifdef GCD_ITER_COUNT_EN
   logic [WIDTH-1:0] iter_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   gcd_engine #(.WIDTH(WIDTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .gcd_out   (gcd_out),
`ifdef GCD_ITER_COUNT_EN
      .zero_err  (zero_err),
      .iter_cnt  (iter_cnt)
`else
      .zero_err  (zero_err)
`endif
   );

   // Stimulus only: hands one pair in and reports what came out and after how many edges.
   task automatic run_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output int lat, output logic [WIDTH-1:0] g,
                          output logic z, output logic [WIDTH-1:0] it);
      int guard;
      guard = 0;
      @(negedge clock);
      while (!in_ready && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      a_in = a;
      b_in = b;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 600) begin
         @(posedge clock);
         #1;
         lat++;
      end
      g = gcd_out;
      z = zero_err;
`ifdef GCD_ITER_COUNT_EN
      it = iter_cnt;
`else
      it = '0;
`endif
   endtask

   task automatic ack_result();
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || gcd_out !== 8'd0 || zero_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: in_ready=%b out_valid=%b gcd=%0d zero=%b, want 1 0 0 0",
                  in_ready, out_valid, gcd_out, zero_err);
      end
`ifdef GCD_ITER_COUNT_EN
      n_tests++;
      if (iter_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_iter_cnt: got %0d want 0", iter_cnt);
      end
`endif
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int lat;
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] it;
      logic z;
      run_job(8'd10, 8'd5, lat, g, z, it);
      n_tests++;
      if (lat !== 2 || g !== 8'd5 || z !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_10_5: lat=%0d gcd=%0d zero=%b, want 2 5 0", lat, g, z);
      end
      ack_result();
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_ack: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_pairs();
      logic [WIDTH-1:0] av [7] = '{8'd3, 8'd17, 8'd10, 8'd119, 8'd255, 8'd5, 8'd12};
      logic [WIDTH-1:0] bv [7] = '{8'd4, 8'd14, 8'd15, 8'd49,  8'd1,   8'd255, 8'd12};
      logic [WIDTH-1:0] gv [7] = '{8'd1, 8'd1,  8'd5,  8'd7,   8'd1,   8'd5, 8'd12};
      int               nv [7] = '{3,    7,     2,     6,      254,    50,   0};
      int lat;
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] it;
      logic z;
      for (int i = 0; i < 7; i++) begin
         run_job(av[i], bv[i], lat, g, z, it);
         n_tests++;
         if (g !== gv[i] || z !== 1'b0) begin
            n_fail++;
            $display("FAIL pair_result(%0d,%0d): gcd=%0d zero=%b, want %0d 0",
                     av[i], bv[i], g, z, gv[i]);
         end
         n_tests++;
         if (lat !== nv[i] + 1) begin
            n_fail++;
            $display("FAIL pair_latency(%0d,%0d): got %0d want %0d", av[i], bv[i], lat, nv[i] + 1);
         end
`ifdef GCD_ITER_COUNT_EN
         n_tests++;
         if (it !== 8'(nv[i])) begin
            n_fail++;
            $display("FAIL pair_iter_cnt(%0d,%0d): got %0d want %0d", av[i], bv[i], it, nv[i]);
         end
`endif
         ack_result();
      end
   endtask

   task automatic test_zero();
      logic [WIDTH-1:0] av [3] = '{8'd0, 8'd0, 8'd12};
      logic [WIDTH-1:0] bv [3] = '{8'd0, 8'd9, 8'd0};
      logic [WIDTH-1:0] gv [3] = '{8'd0, 8'd9, 8'd12};
      logic             zv [3] = '{1'b1, 1'b0, 1'b0};
      int lat;
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] it;
      logic z;
      for (int i = 0; i < 3; i++) begin
         run_job(av[i], bv[i], lat, g, z, it);
         n_tests++;
         if (lat !== 1 || g !== gv[i] || z !== zv[i]) begin
            n_fail++;
            $display("FAIL zero_case(%0d,%0d): lat=%0d gcd=%0d zero=%b, want 1 %0d %b",
                     av[i], bv[i], lat, g, z, gv[i], zv[i]);
         end
         ack_result();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      int extra;
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] it;
      logic z;
      run_job(8'd119, 8'd49, lat, g, z, it);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         in_valid = c[0];
         a_in = 8'd6;
         b_in = 8'd4;
         if (out_valid !== 1'b1 || gcd_out !== 8'd7 || zero_err !== 1'b0 || in_ready !== 1'b0) bad++;
      end
      @(negedge clock);
      in_valid = 1'b0;
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL hold_stable: %0d unstable cycles, want 0", bad);
      end
      ack_result();
      extra = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (out_valid !== 1'b0 || in_ready !== 1'b1) extra++;
      end
      n_tests++;
      if (extra != 0) begin
         n_fail++;
         $display("FAIL no_queued_job: %0d non-idle cycles after ack, want 0", extra);
      end
   endtask

   task automatic test_mid_reset();
      int lat;
      int bad;
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] it;
      logic z;
      @(negedge clock);
      a_in = 8'd255;
      b_in = 8'd1;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || gcd_out !== 8'd0 || zero_err !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: in_ready=%b out_valid=%b gcd=%0d zero=%b, want 1 0 0 0",
                  in_ready, out_valid, gcd_out, zero_err);
      end
      @(negedge clock);
      reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         if (out_valid !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL aborted_job_result: out_valid high %0d cycles, want 0", bad);
      end
      run_job(8'd10, 8'd15, lat, g, z, it);
      n_tests++;
      if (lat !== 3 || g !== 8'd5 || z !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset_job: lat=%0d gcd=%0d zero=%b, want 3 5 0", lat, g, z);
      end
      ack_result();
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] av [5] = '{8'd10, 8'd3, 8'd0, 8'd119, 8'd12};
      logic [WIDTH-1:0] bv [5] = '{8'd5,  8'd4, 8'd9, 8'd49,  8'd0};
      logic [WIDTH-1:0] gv [5] = '{8'd5,  8'd1, 8'd9, 8'd7,   8'd12};
      int sent;
      int rcv;
      int order_err;
      int gap_err;
      int cyc;
      logic hs_in;
      logic hs_out;
      logic prev_out;
      sent = 0;
      rcv = 0;
      order_err = 0;
      gap_err = 0;
      prev_out = 1'b0;
      out_ready = 1'b1;
      for (cyc = 0; cyc < 400; cyc++) begin
         @(negedge clock);
         if (prev_out && in_ready !== 1'b1) gap_err++;
         if (in_ready === 1'b1 && out_valid === 1'b1) gap_err++;
         in_valid = (sent < 5);
         a_in = (sent < 5) ? av[sent] : 8'd0;
         b_in = (sent < 5) ? bv[sent] : 8'd0;
         #1;
         hs_in = in_valid && in_ready;
         hs_out = out_valid;
         if (hs_out) begin
            if (rcv >= 5) order_err++;
            else if (gcd_out !== gv[rcv]) order_err++;
            rcv++;
         end
         prev_out = hs_out;
         @(posedge clock);
         if (hs_in) sent++;
         if (rcv >= 5 && cyc > 0 && sent >= 5 && !hs_out && !out_valid) break;
      end
      repeat (5) begin
         @(negedge clock);
         in_valid = 1'b0;
         if (out_valid) rcv++;
      end
      out_ready = 1'b0;
      n_tests++;
      if (rcv != 5) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d results want 5", rcv);
      end
      n_tests++;
      if (order_err != 0) begin
         n_fail++;
         $display("FAIL b2b_order: %0d wrong results want 0", order_err);
      end
      n_tests++;
      if (gap_err != 0) begin
         n_fail++;
         $display("FAIL b2b_idle_gap: %0d gap violations want 0", gap_err);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pairs();
      test_zero();
      test_backpressure();
      test_mid_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
